// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch FSM encoding and default fetch-path widths.
package sisc_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DRAIN = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// First-word-fall-through queue of {pc, word} entries for the fetch buffer.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_f,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            push_word,
    input  logic [AW-1:0]            push_pc,
    output logic [DW-1:0]            head_word,
    output logic [AW-1:0]            head_pc,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [DW-1:0] word_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            word_mem[wptr] <= push_word;
            pc_mem[wptr]   <= push_pc;
        end
    end

    assign head_word = empty ? '0 : word_mem[rptr];
    assign head_pc   = empty ? '0 : pc_mem[rptr];

endmodule

// File: rtl/ifetch_buf.sv
// Instruction prefetch buffer: runs sequential fetches ahead of the core into
// a small FWFT queue and restarts at the target on a taken branch.
module ifetch_buf
    import sisc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic          im_req,
    output logic [AW-1:0] im_addr,
    input  logic          im_ack,
    input  logic [DW-1:0] im_data,
    input  logic          ir_load,
    output logic          instr_valid,
    output logic [DW-1:0] instr_out,
    output logic [AW-1:0] instr_pc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [AW-1:0] fpc;
    logic [AW-1:0] req_addr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          flush;
    logic          space_now;
    logic          space_after;
    logic          start_req;

    // Space is judged after this cycle's pop so a full queue being drained can
    // keep fetching without a bubble.
    assign pop         = ir_load & ~empty;
    assign space_now   = (count < DEPTH_C) | pop;
    assign count_after = pop ? count : count + 1'b1;
    assign space_after = (count_after < DEPTH_C);
    assign start_req   = (state == IDLE) & ~redirect & space_now;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_req) state_nxt = REQ;
            end
            REQ: begin
                if (im_ack) begin
                    if (redirect || !space_after) state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (im_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A word already requested before a redirect still has to come back in
    // DRAIN; only REQ acknowledgements are ever pushed.
    always_comb begin
        im_req  = (state == REQ) || (state == DRAIN);
        im_addr = im_req ? req_addr : '0;
        push    = (state == REQ) && im_ack && !redirect;
        flush   = redirect;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            fpc      <= '0;
            req_addr <= '0;
        end else begin
            if (redirect)  fpc <= redirect_addr;
            else if (push) fpc <= req_addr + 1'b1;

            if (start_req)                 req_addr <= fpc;
            else if (push && space_after)  req_addr <= req_addr + 1'b1;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_f     (rst_f),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_word (im_data),
        .push_pc   (req_addr),
        .head_word (instr_out),
        .head_pc   (instr_pc),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign instr_valid = ~empty;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_f)
        !(push && full));

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_f)
        (im_req && !im_ack) |=> (im_req && $stable(im_addr)));

    a_legal_state: assert property (@(posedge clk) disable iff (!rst_f)
        state != 2'b11);

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: table-driven fill/drain, directed redirect and reset
// corner cases, and randomized traffic against a queue-level reference model.
module tb_ifetch_buf;
    import sisc_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_f = 1'b0;
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic          im_ack = 1'b0;
    logic [DW-1:0] im_data;
    logic          ir_load = 1'b0;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    // Memory model: mem[i] = 0xA0000000 + i, zero-wait data for the current address.
    assign im_data = 32'hA000_0000 + 32'(im_addr);

    ifetch_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_ack        (im_ack),
        .im_data       (im_data),
        .ir_load       (ir_load),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_f = 1'b0;
        im_ack = 1'b0;
        ir_load = 1'b0;
        redirect = 1'b0;
        redirect_addr = '0;
        #1;
        chk("rst_im_req", 32'(im_req), 0);
        chk("rst_im_addr", 32'(im_addr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);
        step();
        step();
        rst_f = 1'b1;
    endtask

    task automatic chk_head(input string name, input logic [15:0] pc);
        chk({name, "_valid"}, 32'(instr_valid), 1);
        chk({name, "_pc"}, 32'(instr_pc), 32'(pc));
        chk({name, "_word"}, instr_out, 32'hA000_0000 + 32'(pc));
    endtask

    // ---------------- reference model (queue level) ----------------
    typedef struct {
        logic [15:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    bit          model_en = 1'b0;
    logic [15:0] fetch_exp;
    bit          stale;
    bit          req_known;
    bit          req_exp;
    bit          hold_prev;
    logic [15:0] addr_prev;

    task automatic model_init();
        mq.delete();
        fetch_exp = '0;
        stale     = 1'b0;
        req_known = 1'b1;
        req_exp   = 1'b0;
        hold_prev = 1'b0;
        addr_prev = '0;
    endtask

    always @(negedge clk) begin
        if (model_en) begin
            int  prev;
            bit  do_pop;
            ent_t e;
            chk("m_valid", 32'(instr_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_pc", 32'(instr_pc), 32'(mq[0].pc));
                chk("m_word", instr_out, mq[0].word);
            end
            if (req_known) chk("m_req", 32'(im_req), 32'(req_exp));
            if (hold_prev) chk("m_addr_hold", 32'(im_addr), 32'(addr_prev));
            if (im_req && !stale) chk("m_fetch_addr", 32'(im_addr), 32'(fetch_exp));

            // What the coming clock edge must do, from the queue's point of view.
            prev      = mq.size();
            do_pop    = ir_load && (prev > 0);
            hold_prev = 1'b0;
            req_known = 1'b1;
            if (redirect) begin
                mq.delete();
                fetch_exp = redirect_addr;
                stale     = im_req && !im_ack;
                req_exp   = im_req && !im_ack;
                hold_prev = im_req && !im_ack;
                addr_prev = im_addr;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (im_req && im_ack) begin
                    if (stale) begin
                        stale   = 1'b0;
                        req_exp = 1'b0;
                    end else begin
                        e.pc   = fetch_exp;
                        e.word = 32'hA000_0000 + 32'(fetch_exp);
                        mq.push_back(e);
                        fetch_exp = fetch_exp + 16'd1;
                        chk("m_no_overflow", 32'(mq.size() <= DEPTH), 1);
                        req_exp = (mq.size() < DEPTH);
                    end
                end else if (im_req) begin
                    req_exp   = 1'b1;
                    hold_prev = 1'b1;
                    addr_prev = im_addr;
                end else begin
                    req_exp = (prev < DEPTH) || do_pop;
                end
            end
        end
    end

    // ---------------- table for fill then sustained drain ----------------
    typedef struct {
        logic        ack;
        logic        ld;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'd1, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'd2, 1'b1, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'd3, 1'b1, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 16'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 16'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 16'd5, 1'b1, 16'd2};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'd6, 1'b1, 16'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'd7, 1'b1, 16'd4};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 16'd8, 1'b1, 16'd5};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 16'd9, 1'b1, 16'd6};

        // Fill to DEPTH with ir_load=0, then drain one word per cycle.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            im_ack  = tbl[i].ack;
            ir_load = tbl[i].ld;
            step();
            chk($sformatf("tbl%0d_req", i), 32'(im_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), 32'(im_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].exp_pc));
                chk($sformatf("tbl%0d_word", i), instr_out, 32'hA000_0000 + 32'(tbl[i].exp_pc));
            end
        end

        // Redirect while a request waits: late data is dropped in DRAIN.
        do_reset();
        im_ack = 1'b1;
        step();
        step();
        chk_head("t4_first", 16'h0000);
        im_ack = 1'b0;
        step();
        chk("t4_wait_req", 32'(im_req), 1);
        chk("t4_wait_addr", 32'(im_addr), 1);
        redirect = 1'b1;
        redirect_addr = 16'h0040;
        step();
        chk("t4_flush_valid", 32'(instr_valid), 0);
        chk("t4_drain_req", 32'(im_req), 1);
        chk("t4_drain_addr", 32'(im_addr), 1);
        chk("t4_drain_state", 32'(dut.state), 32'(DRAIN));
        redirect = 1'b0;
        im_ack = 1'b1;
        step();
        chk("t4_after_drain_req", 32'(im_req), 0);
        chk("t4_after_drain_valid", 32'(instr_valid), 0);
        step();
        chk("t4_refetch_req", 32'(im_req), 1);
        chk("t4_refetch_addr", 32'(im_addr), 32'h0040);
        step();
        chk_head("t4_target", 16'h0040);

        // Redirect and ir_load together with three entries queued.
        do_reset();
        im_ack = 1'b1;
        repeat (4) step();
        chk_head("t5_queued", 16'h0000);
        chk("t5_count3", 32'(dut.count), 3);
        redirect = 1'b1;
        redirect_addr = 16'h1234;
        ir_load = 1'b1;
        step();
        chk("t5_valid", 32'(instr_valid), 0);
        chk("t5_count0", 32'(dut.count), 0);
        redirect = 1'b0;
        ir_load = 1'b0;
        step();
        chk("t5_addr", 32'(im_addr), 32'h1234);
        step();
        chk_head("t5_target", 16'h1234);

        // Address wrap past 0xFFFF, then asynchronous reset mid-request.
        do_reset();
        im_ack = 1'b1;
        step();
        redirect = 1'b1;
        redirect_addr = 16'hFFFE;
        step();
        chk("t6_discard_valid", 32'(instr_valid), 0);
        redirect = 1'b0;
        step();
        chk("t6_addr", 32'(im_addr), 32'hFFFE);
        step();
        chk_head("t6_fffe", 16'hFFFE);
        ir_load = 1'b1;
        step();
        chk_head("t6_ffff", 16'hFFFF);
        step();
        chk_head("t6_0000", 16'h0000);
        im_ack = 1'b0;
        ir_load = 1'b0;
        step();
        chk("t6_req_pending", 32'(im_req), 1);
        rst_f = 1'b0;
        #1;
        chk("t6_async_req", 32'(im_req), 0);
        chk("t6_async_valid", 32'(instr_valid), 0);

        // Randomized traffic against the reference model.
        do_reset();
        model_init();
        model_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            im_ack   = ((c % 3) == 2);
            ir_load  = ($urandom_range(0, 3) != 0);
            redirect = 1'b0;
            step();
        end
        for (int c = 0; c < 2000; c++) begin
            im_ack   = ($urandom_range(0, 3) != 0);
            ir_load  = ($urandom_range(0, 1) == 1);
            redirect = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_addr = 16'hFFFC + 16'($urandom_range(0, 3));
            else                           redirect_addr = 16'($urandom);
            step();
        end
        model_en = 1'b0;
        redirect = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch_buf.md
Name: ifetch_buf

Overview:
- Instruction prefetch buffer between the instruction memory and the instruction register of the SISC core.
- Fetches sequential words ahead of the core into a small first-word-fall-through queue, tagging each word with its PC.
- Presents the head entry to the IR load path.
- On a taken branch or jump, flushes the queue and restarts fetch at the target address.

Parameters:
- DEPTH, 4, queue entries; power of two, 2 to 16.
- AW, 16, instruction address width; matches the PC.
- DW, 32, instruction word width.

Ports:
- clk  in  1  system clock.
- rst_f  in  1  reset; asynchronous, active-low.
- im_req  out  1  fetch request to the instruction memory.
- im_addr  out  AW  fetch address; stable while im_req=1.
- im_ack  in  1  memory returns im_data this cycle; may be tied 1 for zero-wait memory.
- im_data  in  DW  fetched word; valid when im_req & im_ack.
- ir_load  in  1  core consumes the head entry (pop).
- instr_valid  out  1  queue not empty.
- instr_out  out  DW  head instruction word.
- instr_pc  out  AW  address of the head word.
- redirect  in  1  branch taken; flush and refetch.
- redirect_addr  in  AW  new fetch address.

Behaviour:
- Reset (rst_f=0, asynchronous):
  - state=IDLE; fetch pointer fpc=0; req_addr=0; count=0.
  - im_req=0, im_addr=0, instr_valid=0, instr_out=0, instr_pc=0.
- States:
  - IDLE: im_req=0.
  - REQ: im_req=1, im_addr=req_addr.
  - DRAIN: im_req=1, im_addr=req_addr; the returned data will be discarded.
- Space rule: "space" means count minus (ir_load & instr_valid) is less than DEPTH. There is at most one outstanding request.
- IDLE transitions:
  - redirect: fpc <= redirect_addr and flush; stay IDLE.
  - else if space: req_addr <= fpc; go to REQ.
- REQ, handshake completes when im_req & im_ack at the clock edge:
  - ack & !redirect:
    - Push {im_data, req_addr}; fpc <= req_addr+1.
    - If space remains after this push and any same-cycle pop: req_addr <= req_addr+1 and stay REQ. Otherwise go to IDLE.
  - ack & redirect: discard data; flush; fpc <= redirect_addr; go to IDLE.
  - !ack & redirect: flush; fpc <= redirect_addr; go to DRAIN. req_addr is held so the address stays stable.
  - !ack & !redirect: hold.
- DRAIN transitions:
  - ack: discard data; go to IDLE.
  - redirect: fpc <= redirect_addr and flush; remain in DRAIN, or go to IDLE if ack in the same cycle.
- Throughput: 1 word per cycle sustained with im_ack=1.
- Latency: instr_valid rises 2 cycles after the first IDLE cycle following reset release.
- Queue: first-word-fall-through.
  - instr_out and instr_pc always show the head entry.
  - They are 0 and don't-care when empty; the bench checks them only when instr_valid=1.
- Pop: ir_load with instr_valid=0 is ignored. No underflow and no pointer change.
- Push with the queue full cannot occur by construction. An assertion flags it.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Redirect priority: redirect beats ir_load and push in the same cycle. After the edge, count=0 and instr_valid=0.
- Flush: resets the read/write pointers and count. Entry contents need not be cleared.
- Wrap-around:
  - fpc and req_addr wrap modulo 2^AW, so 0xFFFF is followed by 0x0000.
  - Queue pointers wrap modulo DEPTH.
- Reset mid-request: drops im_req immediately (asynchronous). The memory side must tolerate abandoned requests.

Decomposition:
- Shared package sisc_pkg holds:
  - the fetch state enum: IDLE=2'b00, REQ=2'b01, DRAIN=2'b10;
  - the default widths AW and DW.
- One sub-module, ifetch_fifo: parameterized FWFT queue with push, pop, flush, full, empty and count, storing {pc, word}.
- ifetch_buf holds the FSM, fpc, req_addr and the space logic.

Test Plan:
1. Memory words mem[i]=0xA0000000+i, im_ack=1, ir_load=0. Release reset → im_req rises the 2nd cycle; instr_valid rises the 3rd cycle with instr_out=0xA0000000, instr_pc=0. Queue fills to 4; im_req drops.
2. From the full state, ir_load=1 continuously → one word per cycle, instr_pc sequence 0,1,2,3,4,5…; im_req stays 1; count never exceeds 4.
3. im_ack asserted only every 3rd cycle → im_addr is held stable across the wait cycles; the pushed PCs are contiguous with no duplicates.
4. redirect=1, redirect_addr=0x0040 while REQ is waiting (im_ack=0) → next cycle instr_valid=0 and state DRAIN. The late ack data is discarded. Next instr_pc=0x0040 with instr_out=mem[0x40].
5. redirect and ir_load in the same cycle with 3 entries queued → count=0 afterwards; the first word out has instr_pc=redirect_addr.
6. redirect_addr=0xFFFE → instr_pc sequence 0xFFFE, 0xFFFF, 0x0000. Assert rst_f=0 mid-REQ → im_req=0 and instr_valid=0 immediately, without waiting for a clock edge.
